pwm_ramp_scheduler: RTL and testbench

PWM_RAMP_SCHEDULER -- requirements
Module: pwm_ramp_scheduler

---
 rtl/pwm_ramp_scheduler_if.sv | 27 ++
 rtl/pwm_ramp_scheduler.sv | 152 +++++++++++++++
 tb/tb_pwm_ramp_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_scheduler_if.sv
// Request channel of the PWM ramp scheduler: the valid/ready handshake plus
// the ramp parameters (final duty, step size, step interval).
interface pwm_ramp_scheduler_if #(
  parameter int IW = 16
) ();
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_target;
  logic [7:0]    req_step;
  logic [IW-1:0] req_interval;

  modport master (
    output req_valid,
    output req_target,
    output req_step,
    output req_interval,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_target,
    input  req_step,
    input  req_interval,
    output req_ready
  );
endinterface

// File: rtl/pwm_ramp_scheduler.sv
// PWM duty-cycle ramp scheduler. It accepts one ramp request at a time and
// walks duty_out toward the target by a fixed step every 'interval' cycles.
// The last step saturates exactly at the target, so duty_out never wraps.
// An abort freezes duty_out where it is. A reset drops any ramp silently.
module pwm_ramp_scheduler #(
  parameter logic [7:0] RESET_DUTY = 8'h00,
  parameter int         IW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_ramp_scheduler_if.slave   req,
  input  logic                  abort,
  output logic [7:0]            duty_out,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IW-1:0] IW_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IW_ONE  = {{(IW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [7:0]    step_q, step_d;
  logic [IW-1:0] intv_q, intv_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          up_q, up_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [7:0]    gap_s;
  logic [7:0]    next_duty_s;

  // Requests are only taken in IDLE and never while reset is held.
  assign req.req_ready = (state_q == ST_IDLE) && !rst;

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

  // Next duty value for one step: saturate at the target when within one step.
  // The gap is taken in the ramp direction, so it never underflows.
  always_comb begin
    gap_s       = 8'h00;
    next_duty_s = duty_q;
    if (up_q) begin
      gap_s = tgt_q - duty_q;
    end else begin
      gap_s = duty_q - tgt_q;
    end
    if (gap_s <= step_q) begin
      next_duty_s = tgt_q;
    end else if (up_q) begin
      next_duty_s = duty_q + step_q;
    end else begin
      next_duty_s = duty_q - step_q;
    end
  end

  // State machine next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    intv_d    = intv_q;
    cnt_d     = cnt_q;
    up_d      = up_q;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          // A zero step or zero interval would stall the ramp, so it becomes 1.
          tgt_d  = req.req_target;
          step_d = (req.req_step == 8'h00) ? 8'h01 : req.req_step;
          intv_d = (req.req_interval == IW_ZERO) ? IW_ONE : req.req_interval;
          cnt_d  = IW_ZERO;
          up_d   = (req.req_target > duty_q);
          if (req.req_target == duty_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (abort) begin
          // Abort wins over a step that falls due on the same edge.
          state_d   = ST_IDLE;
          cnt_d     = IW_ZERO;
          aborted_d = 1'b1;
        end else if (cnt_q == (intv_q - IW_ONE)) begin
          cnt_d  = IW_ZERO;
          duty_d = next_duty_s;
          if (next_duty_s == tgt_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          cnt_d = cnt_q + IW_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      duty_q    <= RESET_DUTY;
      tgt_q     <= 8'h00;
      step_q    <= 8'h01;
      intv_q    <= IW_ONE;
      cnt_q     <= IW_ZERO;
      up_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      intv_q    <= intv_d;
      cnt_q     <= cnt_d;
      up_q      <= up_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Self-checking bench for pwm_ramp_scheduler. For each request the expected
// duty trajectory is precomputed as a list of values, one per step, and every
// cycle is checked against that list and the step spacing.
module tb_pwm_ramp_scheduler;

  localparam int IW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;
  logic       aborted;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [7:0] model_duty;

  pwm_ramp_scheduler_if #(.IW(IW)) ifc ();

  pwm_ramp_scheduler #(.RESET_DUTY(8'h00), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (ifc.slave),
    .abort    (abort),
    .duty_out (duty_out),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  // Hold reset for two edges and check the cleared state along the way.
  task automatic test_reset(input bit valid_during);
    rst = 1'b1;
    ifc.req_valid    = valid_during;
    ifc.req_target   = 8'h40;
    ifc.req_step     = 8'h10;
    ifc.req_interval = 16'd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      cmp_cnt++;
      if (ifc.req_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL rst_ready: got %b want 0", ifc.req_ready);
      end
      @(posedge clk); #1;
      cmp_cnt++;
      if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
        err_cnt++;
        $display("FAIL rst_outputs: got duty=%h busy=%b done=%b aborted=%b want 00/0/0/0",
                 duty_out, busy, done, aborted);
      end
    end
    rst = 1'b0;
    ifc.req_valid = 1'b0;
    #1;
    cmp_cnt++;
    if (ifc.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL post_rst_ready: got %b want 1", ifc.req_ready);
    end
    model_duty = 8'h00;
  endtask

  // Issue one request and check every cycle until the ramp ends.
  // abort_k > 0 asserts abort on the cycle the k-th step would land.
  task automatic run_ramp(input logic [7:0] t, input logic [7:0] s,
                          input logic [15:0] iv, input int abort_k,
                          input bit hold_valid, input string name);
    logic [7:0] seq[$];
    logic [7:0] v;
    logic [7:0] start;
    logic [7:0] se;
    logic [7:0] exp_duty;
    int ie, len, last, k;
    bit exp_busy, exp_done, exp_abt;
    start = model_duty;
    se = (s == 8'h00) ? 8'h01 : s;
    ie = (iv == 16'd0) ? 1 : int'(iv);
    v = start;
    while (v != t) begin
      if (t > v) v = ((t - v) <= se) ? t : v + se;
      else       v = ((v - t) <= se) ? t : v - se;
      seq.push_back(v);
    end
    len  = seq.size();
    last = (abort_k > 0) ? abort_k * ie : len * ie;

    cmp_cnt++;
    if (ifc.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_ready: got %b want 1", name, ifc.req_ready);
    end
    ifc.req_valid = 1'b1; ifc.req_target = t; ifc.req_step = s; ifc.req_interval = iv;
    @(posedge clk); #1;
    if (!hold_valid) ifc.req_valid = 1'b0;

    for (int n = 0; n <= last + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      k = n / ie;
      if (abort_k > 0 && k >= abort_k) k = abort_k - 1;
      if (k > len) k = len;
      exp_duty = (k == 0) ? start : seq[k-1];
      if (abort_k > 0) begin
        exp_busy = (n < last);
        exp_done = 1'b0;
        exp_abt  = (n == last);
      end else begin
        exp_busy = (n <= last);
        exp_done = (n == last);
        exp_abt  = 1'b0;
      end
      cmp_cnt++;
      if (duty_out !== exp_duty || busy !== exp_busy || done !== exp_done || aborted !== exp_abt) begin
        err_cnt++;
        $display("FAIL %s cyc%0d: got duty=%h busy=%b done=%b aborted=%b want %h/%b/%b/%b",
                 name, n, duty_out, busy, done, aborted, exp_duty, exp_busy, exp_done, exp_abt);
      end
      // Requests while busy must be ignored; scramble fields to prove it.
      if (hold_valid) begin
        ifc.req_target   = 8'($urandom);
        ifc.req_step     = 8'($urandom);
        ifc.req_interval = 16'($urandom_range(0, 3));
        if (n + 1 >= last) ifc.req_valid = 1'b0;
      end
      if (abort_k > 0 && n == last - 1) abort = 1'b1;
      else abort = 1'b0;
    end
    abort = 1'b0;
    ifc.req_valid = 1'b0;
    model_duty = exp_duty;
  endtask

  task automatic test_directed;
    run_ramp(8'h40, 8'h10, 16'd4, 0, 1'b0, "up_basic");
    run_ramp(8'h05, 8'h30, 16'd1, 0, 1'b0, "down_sat");
    run_ramp(8'hF0, 8'hFF, 16'd1, 0, 1'b0, "to_f0");
    run_ramp(8'hFF, 8'h20, 16'd2, 0, 1'b0, "no_wrap");
    run_ramp(8'h00, 8'hFF, 16'd1, 0, 1'b0, "to_00");
    run_ramp(8'h03, 8'h00, 16'd0, 0, 1'b0, "zero_step_iv");
    run_ramp(8'h00, 8'h10, 16'd1, 0, 1'b0, "back_00");
  endtask

  task automatic test_abort;
    run_ramp(8'h80, 8'h10, 16'd3, 3, 1'b0, "abort_3rd");
    // Abort while idle is ignored and does not block acceptance.
    abort = 1'b1;
    run_ramp(8'h20, 8'h20, 16'd1, 0, 1'b0, "abort_idle");
  endtask

  task automatic test_equal_target;
    run_ramp(8'h20, 8'h05, 16'd3, 0, 1'b0, "equal_tgt");
  endtask

  task automatic test_back_to_back;
    run_ramp(8'h60, 8'h08, 16'd2, 0, 1'b1, "busy_ignore");
    run_ramp(8'h10, 8'h07, 16'd1, 0, 1'b1, "b2b");
  endtask

  task automatic test_random;
    for (int r = 0; r < 10; r++) begin
      run_ramp(8'($urandom), 8'($urandom_range(0, 80)), 16'($urandom_range(0, 4)),
               0, 1'($urandom), "rand");
    end
    run_ramp(8'($urandom_range(128, 255)), 8'h04, 16'($urandom_range(1, 3)), 2, 1'b0, "rand_abort");
  endtask

  // Reset in the middle of a ramp cancels it without any pulse.
  task automatic test_reset_mid_ramp;
    test_reset(1'b0);
    ifc.req_valid = 1'b1; ifc.req_target = 8'h80; ifc.req_step = 8'h10; ifc.req_interval = 16'd2;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
    end
    cmp_cnt++;
    if (duty_out !== 8'h30 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_pre: got duty=%h busy=%b want 30/1", duty_out, busy);
    end
    test_reset(1'b1);
    @(posedge clk); #1;
    cmp_cnt++;
    if (busy !== 1'b0 || duty_out !== 8'h00 || done !== 1'b0 || aborted !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_post: got duty=%h busy=%b done=%b aborted=%b want 00/0/0/0",
               duty_out, busy, done, aborted);
    end
    run_ramp(8'h02, 8'h01, 16'd1, 0, 1'b0, "after_rst");
  endtask

  initial begin
    abort = 1'b0;
    rst = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_target = 8'h00;
    ifc.req_step = 8'h00;
    ifc.req_interval = 16'd0;
    model_duty = 8'h00;
    @(posedge clk);
    test_reset(1'b1);
    test_directed();
    test_abort();
    test_equal_target();
    test_back_to_back();
    test_random();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
